// File: rtl/maze_game_pkg.sv
// Shared types and constants for the maze game level/score logic.
//   level_t      : latched difficulty level (NONE when nothing is latched)
//   state_t      : round sequencer states
//   tiles_t      : bonus tile coordinates for one level
//   tiles_of     : per-level bonus tile lookup (all zero for NONE)
//   decode_level : one-hot switch pattern to level, NONE if not exactly one high
package maze_game_pkg;

  typedef enum logic [1:0] {NONE, EASY, MEDIUM, HARD} level_t;

  typedef enum logic [2:0] {IDLE, SELECT, ARMED, PLAY, WIN, LOSE} state_t;

  localparam logic [7:0] START_SCORE_DEF = 8'd60;
  localparam logic [7:0] SCORE_MAX_DEF   = 8'd99;
  localparam logic [7:0] BONUS_DEF       = 8'd5;

  typedef struct packed {
    logic [4:0] plus_x;
    logic [4:0] plus_y;
    logic [4:0] minus_x;
    logic [4:0] minus_y;
  } tiles_t;

  function automatic tiles_t tiles_of(level_t lvl);
    tiles_t t;
    t = '0;
    case (lvl)
      HARD: begin
        t.plus_x  = 5'd1;  t.plus_y  = 5'd21;
        t.minus_x = 5'd3;  t.minus_y = 5'd5;
      end
      MEDIUM: begin
        t.plus_x  = 5'd21; t.plus_y  = 5'd4;
        t.minus_x = 5'd10; t.minus_y = 5'd6;
      end
      EASY: begin
        t.plus_x  = 5'd17; t.plus_y  = 5'd9;
        t.minus_x = 5'd10; t.minus_y = 5'd9;
      end
      default: t = '0;
    endcase
    return t;
  endfunction

  function automatic level_t decode_level(logic hard, logic med, logic easy);
    level_t l;
    case ({hard, med, easy})
      3'b100:  l = HARD;
      3'b010:  l = MEDIUM;
      3'b001:  l = EASY;
      default: l = NONE;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/maze_score_unit.sv
// Score register with saturating bonus/penalty arithmetic and one-shot tile flags.
//   clock, resetn          : clock, async active-low reset
//   load                   : load START_SCORE and clear the used flags
//   upd                    : commit score_nxt and any tile hits this cycle
//   tick, plus_hit, minus_hit : score adjustments (-1, +BONUS, -BONUS)
//   score                  : current score
//   score_nxt              : clamped score if upd were asserted now
//   plus_used, minus_used  : tile consumed this round
module maze_score_unit
  import maze_game_pkg::*;
#(
  parameter logic [7:0] START_SCORE = START_SCORE_DEF,
  parameter logic [7:0] SCORE_MAX   = SCORE_MAX_DEF,
  parameter logic [7:0] BONUS       = BONUS_DEF
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       load,
  input  logic       upd,
  input  logic       tick,
  input  logic       plus_hit,
  input  logic       minus_hit,
  output logic [7:0] score,
  output logic [7:0] score_nxt,
  output logic       plus_used,
  output logic       minus_used
);

  localparam logic signed [8:0] MAX_S   = $signed({1'b0, SCORE_MAX});
  localparam logic signed [8:0] BONUS_S = $signed({1'b0, BONUS});

  logic signed [8:0] sum;

  // score never exceeds SCORE_MAX, so 9-bit signed cannot overflow here
  always_comb begin
    sum = $signed({1'b0, score});
    if (tick)      sum = sum - 9'sd1;
    if (plus_hit)  sum = sum + BONUS_S;
    if (minus_hit) sum = sum - BONUS_S;
    if (sum[8])             score_nxt = 8'd0;
    else if (sum > MAX_S)   score_nxt = SCORE_MAX;
    else                    score_nxt = sum[7:0];
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      score      <= 8'd0;
      plus_used  <= 1'b0;
      minus_used <= 1'b0;
    end else if (load) begin
      score      <= START_SCORE;
      plus_used  <= 1'b0;
      minus_used <= 1'b0;
    end else if (upd) begin
      score <= score_nxt;
      if (plus_hit)  plus_used  <= 1'b1;
      if (minus_hit) minus_used <= 1'b1;
    end
  end

endmodule

// File: rtl/maze_level_controller.sv
// Maze round sequencer: level selection with switch debounce, play, WIN/LOSE.
//   clock, resetn            : clock, async active-low reset
//   hard, med, easy          : level switches (synchronised)
//   start, tick, move        : one-cycle pulses
//   player_x, player_y       : player cell after a move
//   at_exit                  : player is on the exit cell
//   play_hard/medium/easy    : one-hot latched level (ARMED/PLAY only)
//   plus_*/minus_*           : bonus tile coordinates of the latched level
//   plus_used, minus_used    : tile consumed this round
//   score                    : current score
//   playing, win, lose       : state flags
//   maze_reset               : high in IDLE
//
// state  | meaning
// IDLE   | no level; wait for exactly one switch high
// SELECT | pattern captured; must hold STABLE_CYCLES samples
// ARMED  | level latched, score loaded; wait for start
// PLAY   | round running; abort/exit/score/lose in that priority
// WIN    | player reached exit; hold until start
// LOSE   | score hit zero; hold until start
module maze_level_controller
  import maze_game_pkg::*;
#(
  parameter logic [7:0]  START_SCORE   = START_SCORE_DEF,
  parameter logic [7:0]  SCORE_MAX     = SCORE_MAX_DEF,
  parameter logic [7:0]  BONUS         = BONUS_DEF,
  parameter int unsigned STABLE_CYCLES = 1000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       hard,
  input  logic       med,
  input  logic       easy,
  input  logic       start,
  input  logic       tick,
  input  logic       move,
  input  logic [4:0] player_x,
  input  logic [4:0] player_y,
  input  logic       at_exit,
  output logic       play_hard,
  output logic       play_medium,
  output logic       play_easy,
  output logic [4:0] plus_x,
  output logic [4:0] plus_y,
  output logic [4:0] minus_x,
  output logic [4:0] minus_y,
  output logic       plus_used,
  output logic       minus_used,
  output logic [7:0] score,
  output logic       playing,
  output logic       win,
  output logic       lose,
  output logic       maze_reset
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  // the IDLE cycle that captures the pattern counts as the first stable sample
  localparam logic [CW-1:0] CNT_LOAD = CW'(STABLE_CYCLES - 1);

  state_t        state, state_nxt;
  level_t        lvl, lvl_nxt, cap, sw_lvl;
  logic [CW-1:0] cnt;
  logic          load, upd, act_nxt;
  logic          plus_hit, minus_hit;
  logic [7:0]    score_nxt;

  assign sw_lvl    = decode_level(hard, med, easy);
  assign plus_hit  = move && (player_x == plus_x) && (player_y == plus_y) && !plus_used;
  assign minus_hit = move && (player_x == minus_x) && (player_y == minus_y) && !minus_used;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    upd       = 1'b0;
    case (state)
      IDLE:   if (sw_lvl != NONE) state_nxt = SELECT;
      SELECT: begin
        if (sw_lvl != cap) state_nxt = IDLE;
        else if (cnt <= CW'(1)) begin
          state_nxt = ARMED;
          load      = 1'b1;
        end
      end
      ARMED: begin
        if (sw_lvl != lvl) state_nxt = IDLE;
        else if (start)    state_nxt = PLAY;
      end
      PLAY: begin
        if (sw_lvl != lvl) state_nxt = IDLE;
        else if (at_exit)  state_nxt = WIN;
        else begin
          upd = 1'b1;
          if (score_nxt == 8'd0) state_nxt = LOSE;
        end
      end
      WIN, LOSE: if (start) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase

    if (load)                   lvl_nxt = cap;
    else if (state_nxt == IDLE) lvl_nxt = NONE;
    else                        lvl_nxt = lvl;

    act_nxt = (state_nxt == ARMED) || (state_nxt == PLAY);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      lvl         <= NONE;
      cap         <= NONE;
      cnt         <= '0;
      play_hard   <= 1'b0;
      play_medium <= 1'b0;
      play_easy   <= 1'b0;
      {plus_x, plus_y, minus_x, minus_y} <= '0;
      playing     <= 1'b0;
      win         <= 1'b0;
      lose        <= 1'b0;
      maze_reset  <= 1'b1;
    end else begin
      state <= state_nxt;
      lvl   <= lvl_nxt;
      if (state == IDLE && state_nxt == SELECT) begin
        cap <= sw_lvl;
        cnt <= CNT_LOAD;
      end else if (state_nxt == SELECT) begin
        cnt <= cnt - CW'(1);
      end else begin
        cnt <= '0;
      end
      play_hard   <= act_nxt && (lvl_nxt == HARD);
      play_medium <= act_nxt && (lvl_nxt == MEDIUM);
      play_easy   <= act_nxt && (lvl_nxt == EASY);
      {plus_x, plus_y, minus_x, minus_y} <= tiles_of(lvl_nxt);
      playing     <= (state_nxt == PLAY);
      win         <= (state_nxt == WIN);
      lose        <= (state_nxt == LOSE);
      maze_reset  <= (state_nxt == IDLE);
    end
  end

  maze_score_unit #(
    .START_SCORE (START_SCORE),
    .SCORE_MAX   (SCORE_MAX),
    .BONUS       (BONUS)
  ) u_score (
    .clock      (clock),
    .resetn     (resetn),
    .load       (load),
    .upd        (upd),
    .tick       (tick),
    .plus_hit   (plus_hit),
    .minus_hit  (minus_hit),
    .score      (score),
    .score_nxt  (score_nxt),
    .plus_used  (plus_used),
    .minus_used (minus_used)
  );

endmodule

// File: tb/tb_maze_level_controller.sv
// Bench for maze_level_controller: two instances (default start score and 98)
// share one stimulus stream; a behavioural model predicts every output each cycle.
module tb_maze_level_controller;

  localparam int STABLE = 1000;
  localparam int PH_IDLE = 0, PH_SEL = 1, PH_ARM = 2, PH_PLAY = 3, PH_WIN = 4, PH_LOSE = 5;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic hard = 1'b0, med = 1'b0, easy = 1'b0;
  logic start = 1'b0, tick = 1'b0, move = 1'b0, at_exit = 1'b0;
  logic [4:0] player_x = 5'd0, player_y = 5'd0;

  logic       o_ph[2], o_pm[2], o_pe[2], o_pu[2], o_mu[2];
  logic       o_pl[2], o_wn[2], o_ls[2], o_mr[2];
  logic [4:0] o_px[2], o_py[2], o_mx[2], o_my[2];
  logic [7:0] o_sc[2];

  int n_chk = 0;
  int n_err = 0;

  // behavioural model state, one slot per instance
  int         m_ph[2], m_hold[2], m_score[2];
  logic [2:0] m_pat[2], m_lvl[2];
  bit         m_pu[2], m_mu[2];
  int         start_val[2] = '{60, 98};

  always #5 clock = ~clock;

  maze_level_controller u_dut (
    .clock(clock), .resetn(resetn), .hard(hard), .med(med), .easy(easy),
    .start(start), .tick(tick), .move(move), .player_x(player_x), .player_y(player_y),
    .at_exit(at_exit), .play_hard(o_ph[0]), .play_medium(o_pm[0]), .play_easy(o_pe[0]),
    .plus_x(o_px[0]), .plus_y(o_py[0]), .minus_x(o_mx[0]), .minus_y(o_my[0]),
    .plus_used(o_pu[0]), .minus_used(o_mu[0]), .score(o_sc[0]), .playing(o_pl[0]),
    .win(o_wn[0]), .lose(o_ls[0]), .maze_reset(o_mr[0])
  );

  maze_level_controller #(.START_SCORE(8'd98)) u_hi (
    .clock(clock), .resetn(resetn), .hard(hard), .med(med), .easy(easy),
    .start(start), .tick(tick), .move(move), .player_x(player_x), .player_y(player_y),
    .at_exit(at_exit), .play_hard(o_ph[1]), .play_medium(o_pm[1]), .play_easy(o_pe[1]),
    .plus_x(o_px[1]), .plus_y(o_py[1]), .minus_x(o_mx[1]), .minus_y(o_my[1]),
    .plus_used(o_pu[1]), .minus_used(o_mu[1]), .score(o_sc[1]), .playing(o_pl[1]),
    .win(o_wn[1]), .lose(o_ls[1]), .maze_reset(o_mr[1])
  );

  function automatic bit onehot3(logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

  // {plus_x, plus_y, minus_x, minus_y} for a {hard,med,easy} pattern
  function automatic logic [19:0] tiles_of(logic [2:0] l);
    case (l)
      3'b100:  return {5'd1, 5'd21, 5'd3, 5'd5};
      3'b010:  return {5'd21, 5'd4, 5'd10, 5'd6};
      3'b001:  return {5'd17, 5'd9, 5'd10, 5'd9};
      default: return 20'd0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ph[i] = PH_IDLE; m_hold[i] = 0; m_score[i] = 0;
      m_pat[i] = 3'b000; m_lvl[i] = 3'b000; m_pu[i] = 1'b0; m_mu[i] = 1'b0;
    end
  endtask

  task automatic model_advance();
    logic [2:0]  sw;
    logic [19:0] t;
    int          s;
    if (!resetn) return;
    sw = {hard, med, easy};
    for (int i = 0; i < 2; i++) begin
      case (m_ph[i])
        PH_IDLE: if (onehot3(sw)) begin
          m_pat[i] = sw; m_hold[i] = 1; m_ph[i] = PH_SEL;
        end
        PH_SEL: begin
          if (sw != m_pat[i]) m_ph[i] = PH_IDLE;
          else begin
            m_hold[i] = m_hold[i] + 1;
            if (m_hold[i] == STABLE) begin
              m_lvl[i] = m_pat[i]; m_score[i] = start_val[i];
              m_pu[i] = 1'b0; m_mu[i] = 1'b0; m_ph[i] = PH_ARM;
            end
          end
        end
        PH_ARM: begin
          if (sw != m_lvl[i]) begin m_ph[i] = PH_IDLE; m_lvl[i] = 3'b000; end
          else if (start) m_ph[i] = PH_PLAY;
        end
        PH_PLAY: begin
          if (sw != m_lvl[i]) begin m_ph[i] = PH_IDLE; m_lvl[i] = 3'b000; end
          else if (at_exit) m_ph[i] = PH_WIN;
          else begin
            t = tiles_of(m_lvl[i]);
            s = m_score[i] - (tick ? 1 : 0);
            if (move && player_x == t[19:15] && player_y == t[14:10] && !m_pu[i]) begin
              s = s + 5; m_pu[i] = 1'b1;
            end
            if (move && player_x == t[9:5] && player_y == t[4:0] && !m_mu[i]) begin
              s = s - 5; m_mu[i] = 1'b1;
            end
            if (s < 0) s = 0;
            if (s > 99) s = 99;
            m_score[i] = s;
            if (s == 0) m_ph[i] = PH_LOSE;
          end
        end
        default: if (start) begin m_ph[i] = PH_IDLE; m_lvl[i] = 3'b000; end
      endcase
    end
  endtask

  function automatic logic [36:0] exp_vec(int i);
    logic [2:0] pl;
    pl = (m_ph[i] == PH_ARM || m_ph[i] == PH_PLAY) ? m_lvl[i] : 3'b000;
    return {pl, tiles_of(m_lvl[i]), m_pu[i], m_mu[i], m_score[i][7:0],
            m_ph[i] == PH_PLAY, m_ph[i] == PH_WIN, m_ph[i] == PH_LOSE, m_ph[i] == PH_IDLE};
  endfunction

  function automatic logic [36:0] dut_vec(int i);
    return {o_ph[i], o_pm[i], o_pe[i], o_px[i], o_py[i], o_mx[i], o_my[i],
            o_pu[i], o_mu[i], o_sc[i], o_pl[i], o_wn[i], o_ls[i], o_mr[i]};
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if (dut_vec(i) !== exp_vec(i)) begin
        n_err++;
        $display("FAIL cycle_vec[%0d] t=%0t: got %h expected %h", i, $time, dut_vec(i), exp_vec(i));
      end
    end
  end

  task automatic step();
    @(posedge clock);
    model_advance();
    #1;
    start = 1'b0; tick = 1'b0; move = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (3) step();
    chk("reset_maze_reset", int'(o_mr[0]), 1);
    chk("reset_score", int'(o_sc[0]), 0);
    chk("reset_playing", int'(o_pl[0]), 0);
    chk("reset_plus_x", int'(o_px[0]), 0);
    resetn = 1'b1;

    {hard, med, easy} = 3'b101;
    repeat (5) step();
    chk("multi_high_idle", int'(o_mr[0]), 1);
    {hard, med, easy} = 3'b000;
    step();

    // easy: 999 samples not enough, 1000th arms
    easy = 1'b1;
    repeat (STABLE - 1) step();
    chk("easy_999_not_armed", int'(o_pe[0]), 0);
    chk("easy_select_no_reset", int'(o_mr[0]), 0);
    step();
    chk("easy_armed", int'(o_pe[0]), 1);
    chk("easy_score", int'(o_sc[0]), 60);
    chk("easy_plus_x", int'(o_px[0]), 17);
    chk("easy_plus_y", int'(o_py[0]), 9);
    chk("easy_minus_x", int'(o_mx[0]), 10);
    chk("easy_minus_y", int'(o_my[0]), 9);
    start = 1'b1;
    step();
    chk("easy_playing", int'(o_pl[0]), 1);
    easy = 1'b0;
    step();
    chk("easy_abort_level", int'(o_pe[0]), 0);
    easy = 1'b1;
    repeat (STABLE - 1) step();
    easy = 1'b0;
    step();
    chk("easy_drop_at_999", int'(o_mr[0]), 1);
    chk("easy_drop_level", int'(o_pe[0]), 0);

    // medium: plus tile is one-shot
    med = 1'b1;
    repeat (STABLE) step();
    start = 1'b1;
    step();
    player_x = 5'd21; player_y = 5'd4; move = 1'b1;
    step();
    chk("med_plus_first", int'(o_sc[0]), 65);
    chk("med_plus_used", int'(o_pu[0]), 1);
    chk("hi_plus_saturate", int'(o_sc[1]), 99);
    move = 1'b1;
    step();
    chk("med_plus_second", int'(o_sc[0]), 65);
    med = 1'b0;
    step();
    chk("med_toggle_level", int'(o_pm[0]), 0);
    chk("med_toggle_reset", int'(o_mr[0]), 1);

    // hard: drain to 3, minus tile plus tick clamps to 0
    hard = 1'b1;
    repeat (STABLE) step();
    start = 1'b1;
    step();
    for (int k = 0; k < 57; k++) begin
      tick = 1'b1;
      step();
    end
    chk("hard_score_3", int'(o_sc[0]), 3);
    player_x = 5'd3; player_y = 5'd5; move = 1'b1; tick = 1'b1;
    step();
    chk("hard_clamp_zero", int'(o_sc[0]), 0);
    chk("hard_lose", int'(o_ls[0]), 1);
    chk("hi_minus_tick", int'(o_sc[1]), 35);
    start = 1'b1;
    step();
    chk("lose_start_idle", int'(o_mr[0]), 1);
    hard = 1'b0;
    step();
    chk("hi_abort_idle", int'(o_mr[1]), 1);

    // easy: saturation at 99 on the high-start instance, then exit with tick
    easy = 1'b1;
    repeat (STABLE) step();
    start = 1'b1;
    step();
    tick = 1'b1;
    step();
    chk("hi_score_97", int'(o_sc[1]), 97);
    player_x = 5'd17; player_y = 5'd9; move = 1'b1; tick = 1'b1;
    step();
    chk("hi_clamp_99", int'(o_sc[1]), 99);
    tick = 1'b1;
    step();
    chk("hi_tick_98", int'(o_sc[1]), 98);
    for (int k = 0; k < 52; k++) begin
      tick = 1'b1;
      step();
    end
    chk("easy_score_10", int'(o_sc[0]), 10);
    at_exit = 1'b1; tick = 1'b1;
    step();
    at_exit = 1'b0;
    chk("exit_win", int'(o_wn[0]), 1);
    chk("exit_score_frozen", int'(o_sc[0]), 10);
    easy = 1'b0;
    step();
    chk("win_ignores_switch", int'(o_wn[0]), 1);
    start = 1'b1;
    step();
    chk("win_start_idle", int'(o_mr[0]), 1);
    chk("win_cleared", int'(o_wn[0]), 0);

    // async reset in the middle of a round
    med = 1'b1;
    repeat (STABLE) step();
    start = 1'b1;
    step();
    tick = 1'b1;
    step();
    resetn = 1'b0;
    model_reset();
    #2;
    chk("async_rst_score", int'(o_sc[0]), 0);
    chk("async_rst_maze_reset", int'(o_mr[0]), 1);
    chk("async_rst_playing", int'(o_pl[0]), 0);
    chk("async_rst_level", int'(o_pm[0]), 0);
    chk("async_rst_plus_x", int'(o_px[0]), 0);
    med = 1'b0;
    repeat (2) step();
    resetn = 1'b1;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/maze_level_controller.md
Name: maze_level_controller

Overview:
- Sequences one maze round: validates the three difficulty switches, latches a level, runs play, and ends the round as WIN or LOSE.
- Owns the score counter and the one-shot +5/-5 bonus tiles. Their coordinates are taken per level from the shared constant table.
- Sits between the board switches/keys and the maze draw/move logic. Drives the level-select and score inputs of those blocks.

Parameters:
- START_SCORE, 60, score loaded at round start (8-bit).
- SCORE_MAX, 99, saturation ceiling.
- BONUS, 5, magnitude of each bonus tile.
- STABLE_CYCLES, 1000, cycles a valid switch pattern must hold unchanged before the level is accepted.

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- hard, med, easy  in  1 each  level switches (already synchronised)
- start  in  1  one-cycle pulse; begins a round from ARMED, returns to IDLE from WIN or LOSE
- tick  in  1  one-cycle pulse once per second
- move  in  1  one-cycle pulse when the player position updates
- player_x, player_y  in  5 each  player cell after the move
- at_exit  in  1  level, high while the player is on the exit cell
- play_hard, play_medium, play_easy  out  1 each  one-hot latched level, all 0 outside ARMED/PLAY
- plus_x, plus_y, minus_x, minus_y  out  5 each  bonus tile coordinates of the latched level; 0 when no level is latched
- plus_used, minus_used  out  1 each  tile already consumed this round
- score  out  8  current score
- playing, win, lose  out  1 each  state flags
- maze_reset  out  1  high in IDLE; clears the maze datapath

Behaviour:
- Reset, asynchronous: state=IDLE, score=0, all flags 0 except maze_reset=1, coordinates 0.
- All outputs are registered. Each state's outputs appear the cycle after entry.
- IDLE: wait for exactly one switch high.
  - On a valid pattern, load the stability counter and go to SELECT.
  - All-zero or multi-high patterns stay in IDLE.
- SELECT:
  - The counter counts while the pattern equals the captured one.
  - Any change, including to invalid, returns to IDLE and clears the counter.
  - At STABLE_CYCLES, latch the level and its coordinates, then go to ARMED.
- ARMED:
  - Level outputs are valid and score = START_SCORE.
  - start -> PLAY.
  - A switch change -> IDLE.
- PLAY, evaluated each cycle in this priority order:
  1. Switch pattern differs from the latched level -> IDLE (abort; maze_reset asserted the next cycle).
  2. at_exit -> WIN. Score is frozen and no bonus or tick is applied that cycle.
  3. Score update. Compute score' from tick (-1), +5 (if move lands on the plus tile and plus_used=0), and -5 (if move lands on the minus tile and minus_used=0).
     - Use 9-bit signed intermediate arithmetic, then clamp to 0..SCORE_MAX.
     - Tick and bonus in the same cycle both apply.
     - Setting the used flag coincides with the score change.
  4. If score' == 0 -> LOSE, with score=0 registered.
- WIN/LOSE: hold score and flags.
  - start -> IDLE.
  - A switch change is ignored.
- The plus and minus tiles can never coincide: the constants differ per level.
- The used flags clear on entry to ARMED.
- Reset mid-round returns everything to reset values immediately.

Decomposition:
- Package maze_game_pkg holds:
  - The level enum: NONE, EASY, MEDIUM, HARD.
  - The state enum: IDLE, SELECT, ARMED, PLAY, WIN, LOSE.
  - Bonus coordinates per level:
    - hard: plus (1,21), minus (3,5)
    - medium: plus (21,4), minus (10,6)
    - easy: plus (17,9), minus (10,9)
  - START_SCORE/SCORE_MAX defaults.
- One sub-module, maze_score_unit: the score register, saturating add/sub and the used flags, driven by load/tick/hit strobes from the FSM.

Test Plan:
- easy=1 held 1000 cycles, then start -> play_easy=1, plus=(17,9), minus=(10,9), score=60, playing=1; with easy held 999 cycles then dropped, the block returns to IDLE and play_easy=0.
- Medium round, move to (21,4) twice -> score 65 after the first move, 65 after the second; plus_used=1.
- Hard round, score=3, move to (3,5) coincident with tick -> score clamps to 0; lose=1 on the next cycle.
- Easy round, score=97, plus hit plus tick -> 99 (97+5-1=101 clamped), then the next tick -> 98.
- at_exit and tick in the same cycle at score=10 -> win=1, score stays 10; start -> IDLE, maze_reset=1.
- Toggling med during PLAY -> IDLE next cycle with all level outputs 0; resetn pulsed low mid-PLAY -> reset values asynchronously.
